// File: rtl/tsv_link_pkg.sv
// Shared definitions for the TSV data link: payload width, link states,
// training pattern default and the parity helper used by the RX stage.
package tsv_link_pkg;

  localparam int TSV_DW = 8;
  localparam logic [7:0] TRAIN_PAT_DEFAULT = 8'hA5;

  typedef enum logic {
    TRAIN = 1'b0,
    RUN   = 1'b1
  } link_state_t;

  // Odd result means the word plus its parity bit broke even parity.
  function automatic logic par_bad(input logic [63:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/tsv_rx_fifo.sv
// Small synchronous FIFO buffering received payload words; the head entry
// is presented combinationally from the storage array.
module tsv_rx_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (level_r == LW'(DEPTH));
  assign empty     = (level_r == LW'(0));
  assign level     = level_r;
  assign rdata     = mem_r[rd_ptr_r];
  // A pop frees the slot on the same edge, so a push into a full FIFO is fine then.
  assign do_push_s = push && (!full || pop);
  assign do_pop_s  = pop && !empty;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/tsv_link_rx.sv
// Far-die receive stage of the TSV link: capture, training FSM, payload FIFO.
// Parity checking and parity-driven retrain are enabled by TSV_RX_PARITY_EN.
module tsv_link_rx
  import tsv_link_pkg::*;
#(
  parameter int          DW        = TSV_DW,
  parameter int          DEPTH     = 4,
  parameter int          TRAIN_LEN = 4,
  parameter logic [63:0] TRAIN_PAT = 64'(TRAIN_PAT_DEFAULT),
  parameter int          MAX_ERR   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DW-1:0]          tsv_data,
  input  logic                   tsv_valid,
  input  logic                   tsv_par,
  output logic [DW-1:0]          m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   link_up,
  output logic                   ovf_flag,
  output logic [7:0]             par_err_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int TW = $clog2(TRAIN_LEN + 1);
  localparam logic [DW-1:0] PAT = TRAIN_PAT[DW-1:0];

  logic [DW-1:0] c_data_r;
  logic          c_valid_r;
  logic          c_par_r;
  link_state_t   state_r;
  logic [TW-1:0] train_cnt_r;
  logic          link_up_r;
  logic          ovf_r;
  logic          push_s;
  logic          pop_s;
  logic          bad_s;
  logic          full_s;
  logic          empty_s;

  // Capture stage: every decision below works on these registered copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_data_r  <= '0;
      c_valid_r <= 1'b0;
      c_par_r   <= 1'b0;
    end else begin
      c_data_r  <= tsv_data;
      c_valid_r <= tsv_valid;
      c_par_r   <= tsv_par;
    end
  end

`ifdef TSV_RX_PARITY_EN
  localparam int EW = $clog2(MAX_ERR + 1);
  logic [EW-1:0] err_cnt_r;
  logic [7:0]    par_cnt_r;
  assign bad_s       = par_bad(64'({c_data_r, c_par_r}));
  assign par_err_cnt = par_cnt_r;
`else
  logic unused_par_s;
  assign unused_par_s = c_par_r;
  assign bad_s        = 1'b0;
  assign par_err_cnt  = 8'h00;
`endif

  // Payload push decision; bad-parity words never reach the FIFO.
  always_comb begin
    push_s = 1'b0;
    if (state_r == RUN && c_valid_r && !bad_s) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  assign pop_s = !empty_s && m_ready;

  // Link FSM with training count, overflow flag and parity bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= TRAIN;
      train_cnt_r <= '0;
      link_up_r   <= 1'b0;
      ovf_r       <= 1'b0;
`ifdef TSV_RX_PARITY_EN
      err_cnt_r   <= '0;
      par_cnt_r   <= 8'h00;
`endif
    end else begin
      if (push_s && full_s && !pop_s) begin
        ovf_r <= 1'b1;
      end
      case (state_r)
        TRAIN: begin
          if (c_valid_r && c_data_r == PAT) begin
            if (train_cnt_r == TW'(TRAIN_LEN - 1)) begin
              state_r     <= RUN;
              link_up_r   <= 1'b1;
              train_cnt_r <= '0;
            end else begin
              train_cnt_r <= train_cnt_r + TW'(1);
            end
          end else if (c_valid_r) begin
            train_cnt_r <= '0;
          end
        end
        RUN: begin
`ifdef TSV_RX_PARITY_EN
          if (c_valid_r && bad_s) begin
            if (par_cnt_r != 8'hFF) par_cnt_r <= par_cnt_r + 8'd1;
            if (err_cnt_r == EW'(MAX_ERR - 1)) begin
              err_cnt_r   <= '0;
              state_r     <= TRAIN;
              link_up_r   <= 1'b0;
              train_cnt_r <= '0;
            end else begin
              err_cnt_r <= err_cnt_r + EW'(1);
            end
          end else if (c_valid_r) begin
            err_cnt_r <= '0;
          end
`endif
        end
        default: begin
          state_r   <= TRAIN;
          link_up_r <= 1'b0;
        end
      endcase
    end
  end

  tsv_rx_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (c_data_r),
    .rdata (m_data),
    .full  (full_s),
    .empty (empty_s),
    .level (fifo_level)
  );

  assign m_valid  = !empty_s;
  assign link_up  = link_up_r;
  assign ovf_flag = ovf_r;

endmodule

// File: tb/tb_tsv_link_rx.sv
// Directed self-checking bench for tsv_link_rx; define TSV_RX_PARITY_EN on
// both RTL and bench to exercise the parity build.
module tb_tsv_link_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tsv_data = 8'h00;
  logic       tsv_valid = 1'b0;
  logic       tsv_par = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       link_up;
  logic       ovf_flag;
  logic [7:0] par_err_cnt;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tsv_link_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tsv_data    (tsv_data),
    .tsv_valid   (tsv_valid),
    .tsv_par     (tsv_par),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .link_up     (link_up),
    .ovf_flag    (ovf_flag),
    .par_err_cnt (par_err_cnt),
    .fifo_level  (fifo_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs, then return 1 time unit after the edge that samples them.
  task automatic step(input logic v, input logic [7:0] d, input logic p, input logic rdy);
    tsv_valid = v;
    tsv_data  = d;
    tsv_par   = p;
    m_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic rdy);
    step(1'b1, d, ^d, rdy);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 8'h00, 1'b0, rdy);
  endtask

  task automatic do_reset();
    tsv_valid = 1'b0;
    tsv_data  = 8'h00;
    tsv_par   = 1'b0;
    m_ready   = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1'b0);
  endtask

  task automatic train();
    repeat (4) send(8'hA5, 1'b0);
    idle(1'b0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'h00);
    check("rst_link_up", 32'(link_up), 32'd0);
    check("rst_ovf", 32'(ovf_flag), 32'd0);
    check("rst_par_cnt", 32'(par_err_cnt), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);

    // 1: four patterns then a payload word back to back
    repeat (4) send(8'hA5, 1'b0);
    check("t1_link_not_early", 32'(link_up), 32'd0);
    send(8'h3C, 1'b0);
    check("t1_link_up", 32'(link_up), 32'd1);
    check("t1_no_valid_yet", 32'(m_valid), 32'd0);
    idle(1'b0);
    check("t1_m_valid", 32'(m_valid), 32'd1);
    check("t1_m_data", 32'(m_data), 32'h3C);
    check("t1_pattern_not_stored", 32'(fifo_level), 32'd1);
    idle(1'b1);
    check("t1_drained", 32'(m_valid), 32'd0);

    // 2: broken training sequence must restart the count
    do_reset();
    send(8'hA5, 1'b0);
    send(8'hA5, 1'b0);
    send(8'h11, 1'b0);
    repeat (3) send(8'hA5, 1'b0);
    idle(1'b0);
    check("t2_link_after_3", 32'(link_up), 32'd0);
    send(8'hA5, 1'b0);
    check("t2_link_not_yet", 32'(link_up), 32'd0);
    idle(1'b0);
    check("t2_link_up", 32'(link_up), 32'd1);
    idle(1'b0);
    check("t2_no_data", 32'(m_valid), 32'd0);
    check("t2_level", 32'(fifo_level), 32'd0);

    // 3: overflow with ready low, then ordered drain
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    idle(1'b0);
    check("t3_level_full", 32'(fifo_level), 32'd4);
    check("t3_ovf", 32'(ovf_flag), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("t3_drain_valid", 32'(m_valid), 32'd1);
      check("t3_drain_data", 32'(m_data), 32'(i));
      idle(1'b1);
    end
    check("t3_empty", 32'(m_valid), 32'd0);
    check("t3_ovf_sticky", 32'(ovf_flag), 32'd1);

    // 4: push and pop on the same edge while full
    do_reset();
    train();
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b0);
    send(8'h14, 1'b0);
    check("t4_full", 32'(fifo_level), 32'd4);
    idle(1'b1);
    check("t4_level_kept", 32'(fifo_level), 32'd4);
    check("t4_no_ovf", 32'(ovf_flag), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check("t4_order", 32'(m_data), 32'h10 + 32'(i));
      idle(1'b1);
    end
    check("t4_empty", 32'(fifo_level), 32'd0);

`ifdef TSV_RX_PARITY_EN
    // 5: parity drops and retrain
    do_reset();
    train();
    step(1'b1, 8'h81, 1'b1, 1'b0);
    idle(1'b0);
    check("t5_dropped", 32'(m_valid), 32'd0);
    check("t5_par_cnt1", 32'(par_err_cnt), 32'd1);
    send(8'h22, 1'b0);
    idle(1'b0);
    check("t5_good_word", 32'(m_data), 32'h22);
    idle(1'b1);
    repeat (3) step(1'b1, 8'h81, 1'b1, 1'b0);
    check("t5_link_before", 32'(link_up), 32'd1);
    idle(1'b0);
    check("t5_link_down", 32'(link_up), 32'd0);
    check("t5_par_cnt4", 32'(par_err_cnt), 32'd4);
    send(8'h33, 1'b0);
    idle(1'b0);
    check("t5_train_no_push", 32'(m_valid), 32'd0);
`else
    check("t5_par_tied", 32'(par_err_cnt), 32'd0);
`endif

    // 6: asynchronous reset with data buffered
    do_reset();
    train();
    for (int i = 0; i < 3; i++) send(8'h50 + 8'(i), 1'b0);
    idle(1'b0);
    check("t6_level3", 32'(fifo_level), 32'd3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(m_valid), 32'd0);
    check("t6_rst_data", 32'(m_data), 32'h00);
    check("t6_rst_link", 32'(link_up), 32'd0);
    check("t6_rst_level", 32'(fifo_level), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8'h77, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("t6_needs_train", 32'(m_valid), 32'd0);
    train();
    send(8'h42, 1'b0);
    idle(1'b0);
    check("t6_after_train", 32'(m_data), 32'h42);
    check("t6_valid", 32'(m_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
